// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between instruction fetch and load/store.
// Data has priority, bounded by a streak limit; each transaction has a timeout.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_size,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              m_req,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [1:0]        m_size,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d;
  logic              m_req_q, m_req_d, m_wen_q, m_wen_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [1:0]        m_size_q, m_size_d;
  logic              busy_q, busy_d, timeout_err_q, timeout_err_d;

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    tmo_d         = tmo_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    i_ack_d       = 1'b0;
    d_ack_d       = 1'b0;
    m_req_d       = m_req_q;
    m_wen_d       = m_wen_q;
    m_addr_d      = m_addr_q;
    m_wdata_d     = m_wdata_q;
    m_size_d      = m_size_q;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;
    unique case (state_q)
      IDLE: begin
        if (d_req && (!i_req || streak_q < STREAK_MAX)) begin
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_wen_d   = d_wen;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_size_d  = d_size;
          busy_d    = 1'b1;
          tmo_d     = '0;
          streak_d  = i_req ? streak_q + 4'd1 : '0;
        end else if (i_req) begin
          state_d  = BUSY_I;
          m_req_d  = 1'b1;
          m_wen_d  = 1'b0;
          m_addr_d = i_addr;
          m_size_d = 2'd3;
          busy_d   = 1'b1;
          tmo_d    = '0;
          streak_d = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        // m_ack is checked first so an ack on the threshold cycle completes normally
        if (m_ack || tmo_q == TMO_LAST) begin
          state_d = IDLE;
          m_req_d = 1'b0;
          busy_d  = 1'b0;
          if (!m_ack) timeout_err_d = 1'b1;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = m_ack ? m_rdata : '0;
          end else begin
            d_ack_d = 1'b1;
            if (!m_ack)        d_rdata_d = '0;
            else if (!m_wen_q) d_rdata_d = m_rdata;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      streak_q      <= '0;
      tmo_q         <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
      i_ack_q       <= 1'b0;
      d_ack_q       <= 1'b0;
      m_req_q       <= 1'b0;
      m_wen_q       <= 1'b0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      m_size_q      <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      tmo_q         <= tmo_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
      i_ack_q       <= i_ack_d;
      d_ack_q       <= d_ack_d;
      m_req_q       <= m_req_d;
      m_wen_q       <= m_wen_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      m_size_q      <= m_size_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign i_rdata     = i_rdata_q;
  assign i_ack       = i_ack_q;
  assign d_rdata     = d_rdata_q;
  assign d_ack       = d_ack_q;
  assign m_req       = m_req_q;
  assign m_wen       = m_wen_q;
  assign m_addr      = m_addr_q;
  assign m_wdata     = m_wdata_q;
  assign m_size      = m_size_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are checked on negedge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_ack, d_req, d_wen, d_ack, m_req, m_wen, m_ack, busy, timeout_err;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [1:0]  d_size, m_size;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_size(d_size), .d_rdata(d_rdata), .d_ack(d_ack),
    .m_req(m_req), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_size(m_size), .m_rdata(m_rdata), .m_ack(m_ack),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // expected m_addr on each grant of the starvation sequence
  logic [31:0] grant_addr [6];

  initial begin
    rst = 1'b1; i_req = 0; i_addr = '0; d_req = 0; d_wen = 0; d_addr = '0;
    d_wdata = '0; d_size = '0; m_rdata = '0; m_ack = 0;
    tick(); tick();
    chk("rst_m_req", m_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_terr", timeout_err, 0);

    // single fetch, ack 3 cycles after m_req
    rst = 0; i_req = 1; i_addr = 32'h40;
    tick();
    chk("f_m_req", m_req, 1);
    chk("f_m_addr", m_addr, 32'h40);
    chk("f_m_size", m_size, 3);
    chk("f_m_wen", m_wen, 0);
    chk("f_busy", busy, 1);
    tick(); tick();
    chk("f_no_ack_yet", i_ack, 0);
    m_ack = 1; m_rdata = 32'h00A00093;
    tick();
    chk("f_i_ack", i_ack, 1);
    chk("f_i_rdata", i_rdata, 32'h00A00093);
    chk("f_m_req_drop", m_req, 0);
    chk("f_d_ack", d_ack, 0);
    m_ack = 0; i_req = 0;
    tick();
    chk("f_ack_pulse", i_ack, 0);
    chk("f_idle", busy, 0);

    // simultaneous fetch and store: store wins
    i_req = 1; i_addr = 32'h80;
    d_req = 1; d_wen = 1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; d_size = 3;
    tick();
    chk("s_m_addr", m_addr, 32'h100);
    chk("s_m_wen", m_wen, 1);
    chk("s_m_wdata", m_wdata, 32'hDEADBEEF);
    m_ack = 1; m_rdata = 32'hAAAA5555;
    tick();
    chk("s_d_ack", d_ack, 1);
    chk("s_i_ack", i_ack, 0);
    chk("s_store_rdata", d_rdata, 0);
    d_req = 0; m_ack = 0;
    tick();
    chk("s_fetch_grant", m_addr, 32'h80);
    chk("s_fetch_wen", m_wen, 0);
    m_ack = 1; m_rdata = 32'h1234;
    tick();
    chk("s_f_ack", i_ack, 1);
    chk("s_f_rdata", i_rdata, 32'h1234);
    i_req = 0; m_ack = 0;
    tick();

    // starvation bound: four data grants, one fetch, then data again
    grant_addr[0] = 32'h400; grant_addr[1] = 32'h400; grant_addr[2] = 32'h400;
    grant_addr[3] = 32'h400; grant_addr[4] = 32'h300; grant_addr[5] = 32'h400;
    i_req = 1; i_addr = 32'h300;
    d_req = 1; d_wen = 0; d_addr = 32'h400; d_size = 2;
    m_ack = 1; m_rdata = 32'h55;
    for (int g = 0; g < 6; g++) begin
      tick();
      chk($sformatf("sv_grant%0d_addr", g), m_addr, grant_addr[g]);
      chk($sformatf("sv_grant%0d_req", g), m_req, 1);
      tick();
      chk($sformatf("sv_grant%0d_iack", g), i_ack, (g == 4) ? 1 : 0);
      chk($sformatf("sv_grant%0d_dack", g), d_ack, (g == 4) ? 0 : 1);
    end
    chk("sv_d_rdata", d_rdata, 32'h55);
    i_req = 0; d_req = 0; m_ack = 0;
    tick();

    // timeout: load never acked; requester drops req mid-transaction
    d_req = 1; d_wen = 0; d_addr = 32'h200; d_size = 3;
    tick();
    chk("t_m_addr", m_addr, 32'h200);
    d_req = 0;
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk($sformatf("t_m_req_c%0d", c), m_req, 1);
    end
    chk("t_no_err_yet", timeout_err, 0);
    tick();
    chk("t_abort_m_req", m_req, 0);
    chk("t_abort_dack", d_ack, 1);
    chk("t_abort_rdata", d_rdata, 0);
    chk("t_err", timeout_err, 1);
    tick();
    chk("t_dack_pulse", d_ack, 0);
    m_ack = 1; m_rdata = 32'hBAD;
    tick();
    chk("t_stray_dack", d_ack, 0);
    chk("t_stray_iack", i_ack, 0);
    chk("t_stray_busy", busy, 0);
    chk("t_err_sticky", timeout_err, 1);
    m_ack = 0;

    // ack arriving on the threshold cycle completes normally
    d_req = 1; d_addr = 32'h204;
    tick();
    d_req = 0;
    for (int c = 2; c <= 8; c++) tick();
    chk("th_still_busy", m_req, 1);
    m_ack = 1; m_rdata = 32'h77;
    tick();
    chk("th_dack", d_ack, 1);
    chk("th_rdata", d_rdata, 32'h77);
    m_ack = 0;
    tick();

    // reset during BUSY_I
    i_req = 1; i_addr = 32'h500;
    tick();
    chk("r_busy", busy, 1);
    rst = 1;
    tick();
    chk("r_m_req", m_req, 0);
    chk("r_m_addr", m_addr, 0);
    chk("r_busy0", busy, 0);
    chk("r_i_ack", i_ack, 0);
    chk("r_terr", timeout_err, 0);
    rst = 0;
    tick();
    chk("r_regrant", m_req, 1);
    chk("r_regrant_addr", m_addr, 32'h500);
    m_ack = 1; m_rdata = 32'h99;
    tick();
    chk("r_i_ack2", i_ack, 1);
    chk("r_i_rdata", i_rdata, 32'h99);
    i_req = 0; m_ack = 0;
    tick();

    // input churn while busy, with d_size=0 forwarded
    d_req = 1; d_wen = 0; d_addr = 32'h10; d_size = 0;
    tick();
    chk("c_m_addr", m_addr, 32'h10);
    chk("c_m_size0", m_size, 0);
    d_addr = 32'h20; d_size = 3;
    tick();
    chk("c_hold1", m_addr, 32'h10);
    tick();
    chk("c_hold2", m_addr, 32'h10);
    chk("c_size_hold", m_size, 0);
    m_ack = 1; m_rdata = 32'hC0;
    tick();
    chk("c_dack", d_ack, 1);
    chk("c_rdata", d_rdata, 32'hC0);
    d_req = 0; m_ack = 0;
    tick();
    chk("c_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares a single unified memory port between the pipeline's instruction-fetch requester and its load/store requester. Latches the winning request and drives it to memory as a registered transaction, then waits for the memory acknowledge. Returns read data and a one-cycle acknowledge to the granted requester. Data accesses have priority, with a bounded anti-starvation rule for fetch and a per-transaction timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch waits; range 1..15
TIMEOUT, 64, cycles in a busy state without m_ack before abort; range 2..255

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
i_req  in  1  fetch request; held until i_ack
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetch data, valid when i_ack=1
i_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request; held until d_ack
d_wen  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_size  in  2  encoding: 0 none, 1 byte, 2 half, 3 word
d_rdata  out  DATA_W  load data, valid when d_ack=1
d_ack  out  1  one-cycle data completion pulse
m_req  out  1  memory request, held through the transaction
m_wen  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_size  out  2  access size, same encoding as d_size
m_rdata  in  DATA_W  memory read data, sampled when m_ack=1
m_ack  in  1  memory completion; ignored unless m_req=1
busy  out  1  1 in any BUSY state
timeout_err  out  1  sticky; set on any abort; cleared only by rst

Behaviour:
- All outputs are registered. While rst=1, every output is 0, state is IDLE, and the streak counter and timeout counter are 0.
- State IDLE, no request pending: stay in IDLE.
- State IDLE, d_req=1 and (i_req=0 or streak<MAX_D_STREAK):
  - latch d_addr, d_wdata, d_wen and d_size onto m_*;
  - set m_req=1;
  - go to BUSY_D;
  - streak increments if i_req=1, otherwise it clears to 0.
- State IDLE, otherwise with i_req=1:
  - latch i_addr; set m_wen=0, m_size=3, m_req=1;
  - go to BUSY_I;
  - streak clears to 0.
- Grant decision: uses inputs sampled in IDLE only. m_req rises on the cycle after the request is seen, so the minimum transaction is 2 cycles (IDLE to BUSY, then m_ack).
- BUSY_x with m_ack=1:
  - m_req drops to 0 next cycle;
  - x_rdata takes m_rdata; for a store, x_rdata is left unchanged;
  - x_ack pulses 1 for exactly one cycle;
  - state returns to IDLE.
- Back-to-back rate: the next grant is evaluated in IDLE, so the gap between transactions is at least one IDLE cycle.
- Latched fields are frozen while busy. Changes to i_addr, d_* or req during BUSY are ignored. A requester that drops req mid-transaction still receives its ack.
- The timeout counter clears on entry to BUSY and increments each BUSY cycle without m_ack. When it reaches TIMEOUT-1 with no m_ack:
  - abort: m_req drops to 0;
  - x_ack pulses with x_rdata=0;
  - timeout_err is set;
  - state returns to IDLE.
- m_ack arriving in the same cycle as the timeout threshold: m_ack wins, normal completion, no error.
- m_ack in IDLE, e.g. a late response after an abort or a reset: ignored, no ack pulse.
- Only one of i_ack and d_ack is ever 1 in a cycle.
- Reset mid-transaction: the next cycle shows IDLE, all outputs 0, and no ack pulse for the interrupted request.
- d_size=0 with d_req=1: granted and forwarded unchanged; memory is expected to ack.

Test Plan:
- Single fetch: i_req=1, i_addr=0x40, memory acks 3 cycles after m_req with m_rdata=0x00A00093 -> m_addr=0x40, m_size=3, m_wen=0; then i_ack for one cycle with i_rdata=0x00A00093; then IDLE.
- Simultaneous requests: i_req and d_req both asserted in the same cycle, d_wen=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_size=3 -> data granted first with m_wen=1 and m_wdata=0xDEADBEEF; after d_ack, the fetch is granted.
- Starvation bound, MAX_D_STREAK=4: d_req held continuously, i_req held, 1-cycle memory -> exactly 4 data grants, then 1 fetch grant, then data resumes.
- Timeout, TIMEOUT=8: d_req load to 0x200, memory never acks -> m_req high for 8 cycles then low; d_ack pulses with d_rdata=0; timeout_err=1 and stays 1. A later stray m_ack is ignored.
- Reset mid-op: rst asserted while in BUSY_I -> next cycle all outputs 0, no i_ack. After rst is released, a held i_req is re-granted from IDLE.
- Input churn: d_addr changes from 0x10 to 0x20 while BUSY_D -> m_addr stays 0x10 until d_ack.
